// File: rtl/lms_fir_err.sv
// lms_fir_err: 9-tap time-multiplexed FIR plus error generation for an LMS loop.
// Latency: 10 clocks from the accepting edge to the y_o/error_o register edge; one sample per 11 clocks.
// Backpressure: ready_o is high only in IDLE; a sample offered while busy is dropped and flagged on overrun_o.
//
// Ports:
//   clk_i, rst_n_i           clock (rising edge), asynchronous active-low reset
//   sample_valid_i           data_in / desired_i present this cycle
//   data_in, desired_i       signed 16-bit sample x[n] and desired response d[n]
//   coef1..coef9             signed Q2.14 coefficients, coef1 on x[n] ... coef9 on x[n-8]
//   ready_o                  block idle and accepting (combinational from state)
//   y_o, error_o             registered filter output and d[n] - y (held between pulses)
//   out_valid_o              one-cycle pulse when y_o / error_o update
//   overrun_o                one-cycle pulse when a sample was dropped
//
// Build option: define LMS_FIR_SAT_EN to saturate y and error to 16 bits instead of wrapping.
module lms_fir_err (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               sample_valid_i,
  input  logic signed [15:0] data_in,
  input  logic signed [15:0] desired_i,
  input  logic signed [15:0] coef1,
  input  logic signed [15:0] coef2,
  input  logic signed [15:0] coef3,
  input  logic signed [15:0] coef4,
  input  logic signed [15:0] coef5,
  input  logic signed [15:0] coef6,
  input  logic signed [15:0] coef7,
  input  logic signed [15:0] coef8,
  input  logic signed [15:0] coef9,
  output logic               ready_o,
  output logic signed [15:0] y_o,
  output logic signed [15:0] error_o,
  output logic               out_valid_o,
  output logic               overrun_o
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] x_q    [9];
  logic signed [15:0] snap_q [9];
  logic signed [15:0] coef_in [9];
  logic signed [15:0] desired_q;
  logic signed [35:0] acc_q;
  logic [3:0]         idx_q;
  logic signed [15:0] y_q, err_q;
  logic               out_valid_q, overrun_q;

  logic               is_idle;
  logic               accept;
  logic signed [31:0] prod;
  logic signed [35:0] y_full;
  logic signed [15:0] y16, err16;

  assign coef_in[0] = coef1;
  assign coef_in[1] = coef2;
  assign coef_in[2] = coef3;
  assign coef_in[3] = coef4;
  assign coef_in[4] = coef5;
  assign coef_in[5] = coef6;
  assign coef_in[6] = coef7;
  assign coef_in[7] = coef8;
  assign coef_in[8] = coef9;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_valid_i) state_d = MAC;
      MAC:     if (idx_q == 4'd8) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    is_idle = (state_q == IDLE);
    ready_o = is_idle;
    accept  = is_idle && sample_valid_i;
  end

  // Single shared multiplier: tap k of the delay line against snapshot coefficient k.
  assign prod   = x_q[idx_q] * snap_q[idx_q];
  assign y_full = acc_q >>> 14;

`ifdef LMS_FIR_SAT_EN
  logic signed [16:0] e_full;
  always_comb begin
    if (y_full > 36'sd32767)       y16 = 16'sh7FFF;
    else if (y_full < -36'sd32768) y16 = 16'sh8000;
    else                           y16 = y_full[15:0];
    // 17 bits hold any difference of two 16-bit values exactly.
    e_full = {desired_q[15], desired_q} - {y16[15], y16};
    if (e_full > 17'sd32767)       err16 = 16'sh7FFF;
    else if (e_full < -17'sd32768) err16 = 16'sh8000;
    else                           err16 = e_full[15:0];
  end
`else
  always_comb begin
    y16   = y_full[15:0];
    err16 = desired_q - y16;
  end
`endif

  // Datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 9; i++) begin
        x_q[i]    <= '0;
        snap_q[i] <= '0;
      end
      desired_q   <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      y_q         <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (accept) begin
        x_q[0] <= data_in;
        for (int i = 1; i < 9; i++) x_q[i] <= x_q[i-1];
        for (int i = 0; i < 9; i++) snap_q[i] <= coef_in[i];
        desired_q <= desired_i;
        acc_q     <= '0;
        idx_q     <= '0;
      end
      if (state_q == MAC) begin
        acc_q <= acc_q + 36'(prod);
        idx_q <= idx_q + 4'd1;
      end
      if (state_q == OUT) begin
        y_q   <= y16;
        err_q <= err16;
      end
      out_valid_q <= (state_q == OUT);
      overrun_q   <= sample_valid_i && !is_idle;
    end
  end

  assign y_o         = y_q;
  assign error_o     = err_q;
  assign out_valid_o = out_valid_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_lms_fir_err.sv
// Bench for lms_fir_err: directed scenarios plus randomized traffic against a transaction-level model.
// The model tracks accepted samples as a history array and schedules each result 10 edges after acceptance.
// Outputs are compared every falling edge; inputs change 2 time units after each rising edge.
module tb_lms_fir_err;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               valid;
  logic signed [15:0] din, des;
  logic signed [15:0] c [9];
  logic               ready_o, out_valid_o, overrun_o;
  logic signed [15:0] y_o, error_o;

  int checks = 0;
  int errors = 0;

  lms_fir_err dut (
    .clk_i(clk), .rst_n_i(rst_n), .sample_valid_i(valid),
    .data_in(din), .desired_i(des),
    .coef1(c[0]), .coef2(c[1]), .coef3(c[2]), .coef4(c[3]), .coef5(c[4]),
    .coef6(c[5]), .coef7(c[6]), .coef8(c[7]), .coef9(c[8]),
    .ready_o(ready_o), .y_o(y_o), .error_o(error_o),
    .out_valid_o(out_valid_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output arithmetic straight from the definition: floor(sum / 2^14), then wrap or clamp.
  function automatic void model_out(input longint sum, input longint d,
                                    output logic signed [15:0] y, output logic signed [15:0] e);
    longint yf;
    longint ef;
    yf = sum >>> 14;
`ifdef LMS_FIR_SAT_EN
    if (yf > 32767) yf = 32767;
    if (yf < -32768) yf = -32768;
    y  = yf[15:0];
    ef = d - yf;
    if (ef > 32767) ef = 32767;
    if (ef < -32768) ef = -32768;
    e  = ef[15:0];
`else
    y  = yf[15:0];
    ef = d - longint'(y);
    e  = ef[15:0];
`endif
  endfunction

  // ---------------- behavioural model ----------------
  longint             hist [9];
  int                 cyc = 0;
  int                 last_acc = -1000;
  bit                 pend = 0;
  int                 pend_due = 0;
  logic signed [15:0] pend_y = 0, pend_e = 0;
  logic               m_rdy = 1, m_vld = 0, m_ov = 0;
  logic signed [15:0] m_y = 0, m_e = 0;

  initial begin
    for (int k = 0; k < 9; k++) hist[k] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 9; k++) hist[k] = 0;
        cyc = 0; last_acc = -1000; pend = 0;
        m_rdy = 1; m_vld = 0; m_ov = 0; m_y = 0; m_e = 0;
      end else begin
        longint sum;
        cyc++;
        m_vld = 0;
        m_ov  = 0;
        if (pend && cyc == pend_due) begin
          m_vld = 1; m_y = pend_y; m_e = pend_e; pend = 0;
        end
        if (valid) begin
          if (cyc - last_acc >= 11) begin
            for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = longint'(din);
            sum = 0;
            for (int k = 0; k < 9; k++) sum += hist[k] * longint'(c[k]);
            model_out(sum, longint'(des), pend_y, pend_e);
            pend = 1; pend_due = cyc + 10; last_acc = cyc;
          end else begin
            m_ov = 1;
          end
        end
        m_rdy = (cyc - last_acc >= 10);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("ready_o", ready_o, m_rdy);
      chk("overrun_o", overrun_o, m_ov);
      chk("out_valid_o", out_valid_o, m_vld);
      chk("y_o", y_o, m_y);
      chk("error_o", error_o, m_e);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic clear_coefs();
    for (int k = 0; k < 9; k++) c[k] = 0;
  endtask

  task automatic send(input logic signed [15:0] x, input logic signed [15:0] d);
    int n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    if (!ready_o) chk("send_ready_timeout", 0, 1);
    valid = 1'b1; din = x; des = d;
    @(posedge clk); #2;
    valid = 1'b0;
  endtask

  task automatic get_out(output logic signed [15:0] y, output logic signed [15:0] e, output int lat);
    lat = -1; y = 0; e = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (out_valid_o) begin
        y = y_o; e = error_o; lat = n;
        break;
      end
    end
    if (lat < 0) chk("out_valid_timeout", 0, 1);
  endtask

  logic signed [15:0] ry, re;
  int                 lat;
  int                 ov_cnt, vld_cnt;
  int                 dly_exp [6] = '{0, 0, 0, 0, 1000, 0};
  int                 dly_in  [6] = '{2000, 0, 0, 0, 0, 0};

  initial begin
    rst_n = 1'b0; valid = 1'b0; din = 0; des = 0;
    clear_coefs();

    // Pin the model arithmetic with hand-computed values.
    model_out(longint'(1000) * 16384, 0, ry, re);
    chk("model_impulse_y", ry, 1000);
    chk("model_impulse_e", re, -1000);
    model_out(-1, 5, ry, re);
    chk("model_floor_y", ry, -1);
    chk("model_floor_e", re, 6);
    model_out(longint'(2) * 30000 * 32767, 0, ry, re);
`ifdef LMS_FIR_SAT_EN
    chk("model_sat_y", ry, 32767);
    chk("model_sat_e", re, -32767);
`else
    chk("model_wrap_y", ry, -11076);
    chk("model_wrap_e", re, 11076);
`endif

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Impulse gain and latency.
    c[0] = 16384;
    send(1000, 0);
    get_out(ry, re, lat);
    chk("impulse_y", ry, 1000);
    chk("impulse_e", re, -1000);
    chk("impulse_latency", lat, 10);

    // Delay alignment through tap 5.
    do_reset();
    clear_coefs();
    c[4] = 8192;
    for (int i = 0; i < 6; i++) begin
      send(16'(dly_in[i]), 0);
      get_out(ry, re, lat);
      chk("delay_y", ry, dly_exp[i]);
    end

    // Saturation / wrap on the second of two large samples.
    do_reset();
    clear_coefs();
    c[0] = 32767; c[1] = 32767;
    send(30000, 0);
    get_out(ry, re, lat);
    send(30000, 0);
    get_out(ry, re, lat);
`ifdef LMS_FIR_SAT_EN
    chk("sat_y", ry, 32767);
    chk("sat_e", re, -32767);
`else
    chk("wrap_y", ry, -11076);
    chk("wrap_e", re, 11076);
`endif

    // Valid held high: accepts at E0, E11, E22; overrun on the other 30 edges.
    ov_cnt = 0; vld_cnt = 0;
    valid = 1'b1;
    for (int n = 0; n < 33; n++) begin
      din = 16'($urandom); des = 16'($urandom);
      @(posedge clk); #1;
      if (overrun_o) ov_cnt++;
      if (out_valid_o) vld_cnt++;
    end
    valid = 1'b0;
    chk("held_overrun_count", ov_cnt, 30);
    chk("held_out_valid_count", vld_cnt, 3);

    // Coefficient change after the snapshot must not affect the sample in flight.
    do_reset();
    clear_coefs();
    c[0] = 16384;
    send(500, 0);
    repeat (2) @(posedge clk);
    #1 c[0] = 0;
    get_out(ry, re, lat);
    chk("snapshot_y", ry, 500);

    // Reset in the middle of MAC.
    c[0] = 16384;
    send(777, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_y", y_o, 0);
    chk("rst_e", error_o, 0);
    chk("rst_vld", out_valid_o, 0);
    chk("rst_ov", overrun_o, 0);
    chk("rst_rdy", ready_o, 1);
    @(posedge clk); #2 rst_n = 1'b1;
    vld_cnt = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (out_valid_o) vld_cnt++;
    end
    chk("rst_no_out_valid", vld_cnt, 0);
    send(100, 0);
    get_out(ry, re, lat);
    chk("post_rst_y", ry, 100);
    chk("post_rst_e", re, -100);

    // Randomized traffic: random valids, data, coefficient churn, rare reset pulses.
    do_reset();
    for (int k = 0; k < 9; k++) c[k] = 16'($urandom);
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      rst_n = ($urandom_range(0, 399) != 0);
      valid = ($urandom_range(0, 2) == 0);
      din   = 16'($urandom);
      des   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) c[$urandom_range(0, 8)] = 16'($urandom);
    end
    @(posedge clk); #2;
    rst_n = 1'b1; valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
